// File: rtl/riscv_ctrl_mem_unit.sv
// rtl/riscv_ctrl_mem_unit.sv - RV32I control and memory block
// Instruction ROM, main decoder and word-addressed data RAM for a single-cycle core.

module riscv_ctrl_mem_unit_dec (
  input  logic [31:0] inst_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        rst_i,
  output logic        pc_sel_o,
  output logic [2:0]  imm_sel_o,
  output logic        br_un_o,
  output logic        a_sel_o,
  output logic        b_sel_o,
  output logic [3:0]  alu_sel_o,
  output logic        mem_rw_o,
  output logic        reg_wen_o,
  output logic [1:0]  wb_sel_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC1 = 2'b10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       b30;
  logic       taken;
  logic       pc_sel_raw;
  logic       mem_rw_raw;
  logic       reg_wen_raw;
  logic       unused_inst_bits;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign b30    = inst_i[30];
  assign unused_inst_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = br_eq_i;
      3'b001:         taken = ~br_eq_i;
      3'b100, 3'b110: taken = br_lt_i;
      3'b101, 3'b111: taken = ~br_lt_i;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_sel_raw  = 1'b0;
    imm_sel_o   = IMM_I;
    br_un_o     = 1'b0;
    a_sel_o     = 1'b0;
    b_sel_o     = 1'b0;
    alu_sel_o   = ALU_ADD;
    mem_rw_raw  = 1'b0;
    reg_wen_raw = 1'b0;
    wb_sel_o    = WB_ALU;
    case (opcode)
      OP_R: begin
        alu_sel_o   = {b30, funct3};
        reg_wen_raw = 1'b1;
      end
      OP_I_ALU: begin
        // Only the shift-right immediates carry the arithmetic flag in bit 30.
        b_sel_o     = 1'b1;
        alu_sel_o   = {(funct3 == 3'b101) ? b30 : 1'b0, funct3};
        reg_wen_raw = 1'b1;
      end
      OP_LOAD: begin
        b_sel_o     = 1'b1;
        reg_wen_raw = 1'b1;
        wb_sel_o    = WB_MEM;
      end
      OP_STORE: begin
        imm_sel_o  = IMM_S;
        b_sel_o    = 1'b1;
        mem_rw_raw = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel_o  = IMM_B;
        a_sel_o    = 1'b1;
        b_sel_o    = 1'b1;
        br_un_o    = funct3[1];
        pc_sel_raw = taken;
      end
      OP_LUI: begin
        imm_sel_o   = IMM_U;
        b_sel_o     = 1'b1;
        alu_sel_o   = ALU_PASSB;
        reg_wen_raw = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel_o   = IMM_U;
        a_sel_o     = 1'b1;
        b_sel_o     = 1'b1;
        reg_wen_raw = 1'b1;
      end
      OP_JAL: begin
        imm_sel_o   = IMM_J;
        a_sel_o     = 1'b1;
        b_sel_o     = 1'b1;
        pc_sel_raw  = 1'b1;
        reg_wen_raw = 1'b1;
        wb_sel_o    = WB_PC1;
      end
      OP_JALR: begin
        b_sel_o     = 1'b1;
        pc_sel_raw  = 1'b1;
        reg_wen_raw = 1'b1;
        wb_sel_o    = WB_PC1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every architectural side effect but leaves the datapath selects decoding.
  assign pc_sel_o  = pc_sel_raw  & ~rst_i;
  assign mem_rw_o  = mem_rw_raw  & ~rst_i;
  assign reg_wen_o = reg_wen_raw & ~rst_i;

endmodule

module riscv_ctrl_mem_unit #(
  parameter int IMEM_W  = 32,
  parameter int IMEM_AW = 4,
  parameter int DMEM_W  = 32,
  parameter int DMEM_AW = 16
) (
  input  logic               sysCLK,
  input  logic               pRST,
  input  logic [IMEM_AW-1:0] pcVal,
  output logic [IMEM_W-1:0]  inst,
  input  logic               BrEq,
  input  logic               BrLt,
  output logic               PCSel,
  output logic [2:0]         ImmSel,
  output logic               BrUn,
  output logic               ASel,
  output logic               BSel,
  output logic [3:0]         ALUSel,
  output logic               MemRW,
  output logic               RegWEn,
  output logic [1:0]         WBSel,
  input  logic [DMEM_AW-1:0] addrD,
  input  logic [DMEM_W-1:0]  memDataW,
  output logic [DMEM_W-1:0]  memDataR
);

  localparam logic [IMEM_W-1:0] NOP = IMEM_W'(32'h0000_0013);

  logic [DMEM_W-1:0] mem_q [0:(1 << DMEM_AW)-1];

  always_comb begin
    inst = NOP;
    case (int'(pcVal))
      0:       inst = IMEM_W'(32'h0050_0093);
      1:       inst = IMEM_W'(32'h0030_0113);
      2:       inst = IMEM_W'(32'h0020_81B3);
      3:       inst = IMEM_W'(32'h4020_8233);
      4:       inst = IMEM_W'(32'h0030_2023);
      5:       inst = IMEM_W'(32'h0000_2283);
      6:       inst = IMEM_W'(32'h1234_5337);
      7:       inst = IMEM_W'(32'h0010_8463);
      default: inst = NOP;
    endcase
  end

  riscv_ctrl_mem_unit_dec u_dec (
    .inst_i    (inst[31:0]),
    .br_eq_i   (BrEq),
    .br_lt_i   (BrLt),
    .rst_i     (pRST),
    .pc_sel_o  (PCSel),
    .imm_sel_o (ImmSel),
    .br_un_o   (BrUn),
    .a_sel_o   (ASel),
    .b_sel_o   (BSel),
    .alu_sel_o (ALUSel),
    .mem_rw_o  (MemRW),
    .reg_wen_o (RegWEn),
    .wb_sel_o  (WBSel)
  );

  // MemRW is already gated by pRST, so a store held across reset never lands.
  always_ff @(posedge sysCLK) begin
    if (MemRW) begin
      mem_q[addrD] <= memDataW;
    end
  end

  assign memDataR = mem_q[addrD];

endmodule

// File: tb/tb_riscv_ctrl_mem_unit.sv
// tb/tb_riscv_ctrl_mem_unit.sv - self-checking bench for riscv_ctrl_mem_unit
module tb_riscv_ctrl_mem_unit;

  logic        sysCLK;
  logic        pRST;
  logic [3:0]  pcVal;
  logic [31:0] inst;
  logic        BrEq, BrLt;
  logic        PCSel, BrUn, ASel, BSel, MemRW, RegWEn;
  logic [2:0]  ImmSel;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;
  logic [15:0] addrD;
  logic [31:0] memDataW, memDataR;

  logic [31:0] d_inst;
  logic        d_pcsel, d_brun, d_asel, d_bsel, d_memrw, d_regwen;
  logic [2:0]  d_imm;
  logic [3:0]  d_alu;
  logic [1:0]  d_wb;

  int errors = 0;
  int checks = 0;

  riscv_ctrl_mem_unit dut (
    .sysCLK(sysCLK), .pRST(pRST), .pcVal(pcVal), .inst(inst),
    .BrEq(BrEq), .BrLt(BrLt), .PCSel(PCSel), .ImmSel(ImmSel), .BrUn(BrUn),
    .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel), .MemRW(MemRW), .RegWEn(RegWEn),
    .WBSel(WBSel), .addrD(addrD), .memDataW(memDataW), .memDataR(memDataR)
  );

  riscv_ctrl_mem_unit_dec dec (
    .inst_i(d_inst), .br_eq_i(BrEq), .br_lt_i(BrLt), .rst_i(1'b0),
    .pc_sel_o(d_pcsel), .imm_sel_o(d_imm), .br_un_o(d_brun), .a_sel_o(d_asel),
    .b_sel_o(d_bsel), .alu_sel_o(d_alu), .mem_rw_o(d_memrw), .reg_wen_o(d_regwen),
    .wb_sel_o(d_wb)
  );

  initial sysCLK = 1'b0;
  always #5 sysCLK = ~sysCLK;

  typedef struct {
    bit          rom;
    logic [3:0]  pc;
    logic [31:0] ins;
    logic        eq;
    logic        lt;
    logic        pcsel;
    logic [2:0]  imm;
    logic        brun;
    logic        asel;
    logic        bsel;
    logic [3:0]  alu;
    logic        memrw;
    logic        regwen;
    logic [1:0]  wb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysCLK);
    #1;
  endtask

  function automatic logic [31:0] top_ctrl();
    return 32'({PCSel, ImmSel, BrUn, ASel, BSel, ALUSel, MemRW, RegWEn, WBSel});
  endfunction

  function automatic logic [31:0] dec_ctrl();
    return 32'({d_pcsel, d_imm, d_brun, d_asel, d_bsel, d_alu, d_memrw, d_regwen, d_wb});
  endfunction

  function automatic logic [31:0] exp_ctrl(input vec_t v);
    return 32'({v.pcsel, v.imm, v.brun, v.asel, v.bsel, v.alu, v.memrw, v.regwen, v.wb});
  endfunction

  initial begin
    pRST = 1'b1; pcVal = 4'd4; BrEq = 1'b0; BrLt = 1'b0;
    addrD = 16'h0; memDataW = 32'h0; d_inst = 32'h0;

    // ROM-fetched words (rom=1) then decoder-only encodings (rom=0)
    vecs.push_back('{1, 4'd0, 32'h00500093, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0000, 0, 1, 2'b00});
    vecs.push_back('{1, 4'd1, 32'h00300113, 1, 1, 0, 3'b000, 0, 0, 1, 4'b0000, 0, 1, 2'b00});
    vecs.push_back('{1, 4'd2, 32'h002081B3, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 1, 2'b00});
    vecs.push_back('{1, 4'd3, 32'h40208233, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 0, 1, 2'b00});
    vecs.push_back('{1, 4'd4, 32'h00302023, 0, 0, 0, 3'b001, 0, 0, 1, 4'b0000, 1, 0, 2'b00});
    vecs.push_back('{1, 4'd5, 32'h00002283, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0000, 0, 1, 2'b01});
    vecs.push_back('{1, 4'd6, 32'h12345337, 0, 0, 0, 3'b011, 0, 0, 1, 4'b1001, 0, 1, 2'b00});
    vecs.push_back('{1, 4'd7, 32'h00108463, 1, 0, 1, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{1, 4'd7, 32'h00108463, 0, 1, 0, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    for (int p = 8; p < 16; p++)
      vecs.push_back('{1, 4'(p), 32'h00000013, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0000, 0, 1, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0020E463, 0, 1, 1, 3'b010, 1, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0020E463, 1, 0, 0, 3'b010, 1, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0020D463, 0, 0, 1, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0020D463, 0, 1, 0, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h00209463, 0, 0, 1, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h00209463, 1, 0, 0, 3'b010, 0, 1, 1, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0020E1B3, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0110, 0, 1, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h4030D093, 0, 0, 0, 3'b000, 0, 0, 1, 4'b1101, 0, 1, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h4000C093, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0100, 0, 1, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h0080006F, 0, 0, 1, 3'b100, 0, 1, 1, 4'b0000, 0, 1, 2'b10});
    vecs.push_back('{0, 4'd0, 32'h00008067, 0, 0, 1, 3'b000, 0, 0, 1, 4'b0000, 0, 1, 2'b10});
    vecs.push_back('{0, 4'd0, 32'h00000297, 0, 0, 0, 3'b011, 0, 1, 1, 4'b0000, 0, 1, 2'b00});
    vecs.push_back('{0, 4'd0, 32'h00000000, 1, 1, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 2'b00});
    vecs.push_back('{0, 4'd0, 32'hFFFFFFFF, 1, 1, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 2'b00});

    // Reset state: side effects suppressed, selects still decode
    #2;
    check("rst_sw_memrw", 32'(MemRW), 32'd0);
    check("rst_sw_immsel", 32'(ImmSel), 32'd1);
    pcVal = 4'd0; #1;
    check("rst_addi_regwen", 32'(RegWEn), 32'd0);
    check("rst_addi_bsel", 32'(BSel), 32'd1);
    pcVal = 4'd7; BrEq = 1'b1; #1;
    check("rst_beq_pcsel", 32'(PCSel), 32'd0);
    check("rst_beq_asel", 32'(ASel), 32'd1);

    tick;
    pRST = 1'b0;
    pcVal = 4'd0; BrEq = 1'b0;

    foreach (vecs[i]) begin
      BrEq = vecs[i].eq;
      BrLt = vecs[i].lt;
      if (vecs[i].rom) pcVal = vecs[i].pc;
      else d_inst = vecs[i].ins;
      #1;
      if (vecs[i].rom) begin
        check($sformatf("vec%0d_inst", i), inst, vecs[i].ins);
        check($sformatf("vec%0d_ctrl", i), top_ctrl(), exp_ctrl(vecs[i]));
      end else begin
        check($sformatf("vec%0d_ctrl", i), dec_ctrl(), exp_ctrl(vecs[i]));
      end
    end
    BrEq = 1'b0; BrLt = 1'b0;

    // Store then load through the data RAM
    pcVal = 4'd4; addrD = 16'h0000; memDataW = 32'd8;
    tick;
    check("sw_first", memDataR, 32'd8);
    memDataW = 32'h0000_0055; #1;
    check("rd_during_wr_old", memDataR, 32'd8);
    tick;
    check("rd_after_wr_new", memDataR, 32'h55);
    addrD = 16'hFFFF; memDataW = 32'hA5A5_0001;
    tick;
    check("sw_top_addr", memDataR, 32'hA5A5_0001);
    addrD = 16'h0000; #1;
    check("addr0_untouched", memDataR, 32'h55);

    pcVal = 4'd5; memDataW = 32'h1111_1111; #1;
    check("lw_wbsel", 32'(WBSel), 32'd1);
    check("lw_regwen", 32'(RegWEn), 32'd1);
    check("lw_memrw", 32'(MemRW), 32'd0);
    tick;
    check("lw_no_write", memDataR, 32'h55);

    // Reset asserted mid-run while a store is presented
    pcVal = 4'd4; memDataW = 32'hDEAD_BEEF; pRST = 1'b1; #1;
    check("rst_store_memrw", 32'(MemRW), 32'd0);
    tick;
    check("rst_store_blocked", memDataR, 32'h55);
    pRST = 1'b0; #1;
    check("rel_store_memrw", 32'(MemRW), 32'd1);
    tick;
    check("rel_store_lands", memDataR, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
